// File: rtl/pico_qsys_led_pkg.sv
// ----------------------------------------------------------------------------
// pico_qsys_led_pkg
// Shared constants for the pico_qsys LED / GPIO output PIO slave:
//   - word register offsets of the Avalon-MM register map
//   - the fixed read latency of the slave (readdata is registered once)
// ----------------------------------------------------------------------------
package pico_qsys_led_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;  // R/W output data register
    localparam logic [2:0] ADDR_BLINK  = 3'd1;  // R/W blink mask
    localparam logic [2:0] ADDR_PERIOD = 3'd2;  // R/W blink half-period
    localparam logic [2:0] ADDR_STATUS = 3'd3;  // RO  bit0 = blink phase
    localparam logic [2:0] ADDR_OUTSET = 3'd4;  // WO  data |= wd
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;  // WO  data &= ~wd
    localparam logic [2:0] ADDR_OUTTGL = 3'd6;  // WO  data ^= wd

    // Clocks from the address being presented to readdata being valid.
    localparam int READ_LATENCY = 1;

endpackage : pico_qsys_led_pkg

// File: rtl/pico_qsys_led_blink_timer.sv
// ----------------------------------------------------------------------------
// pico_qsys_led_blink_timer
// Period counter plus phase flop for the LED blink engine. The counter runs
// 0..period and the phase flips on the clock where it matches, so the phase
// holds for period+1 clocks. period==0 parks the engine with phase forced low.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   period   in   PERIOD_WIDTH  half-period minus one (0 = disabled)
//   restart  in   1 on the edge the period register is written; zeroes the
//                 counter and leaves phase alone
//   phase    out  current blink phase
// ----------------------------------------------------------------------------
module pico_qsys_led_blink_timer
    import pico_qsys_led_pkg::*;
#(
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    restart,
    output logic                    phase
);

    logic [PERIOD_WIDTH-1:0] r_cnt;
    logic                    r_phase;

    // NOTE: state flops use non-blocking (<=) so every flop samples the
    // pre-edge values; each flop is cleared by the async reset because the
    // blink sequence must restart cleanly from cnt=0, phase=0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (restart) begin
            // A new period always starts counting from zero, so the counter
            // can never sit above a freshly lowered period.
            r_cnt <= '0;
        end else if (period == '0) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == period) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + PERIOD_WIDTH'(1);
        end
    end

    assign phase = r_phase;

endmodule : pico_qsys_led_blink_timer

// File: rtl/pico_qsys_led.sv
// ----------------------------------------------------------------------------
// pico_qsys_led
// Avalon-MM output PIO slave driving board LEDs / GPIO. Holds an output data
// register with atomic set / clear / toggle aliases and a blink engine that
// inverts the masked output bits while the blink phase is high.
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   3   word register offset
//   chipselect  in   1   slave select, qualifies writes
//   write_n     in   1   active-low write strobe
//   writedata   in   32  write data, bits above register width ignored
//   readdata    out  32  registered read data (1-cycle latency), zero-extended
//   out_port    out  DATA_WIDTH  LED / GPIO drive
// ----------------------------------------------------------------------------
module pico_qsys_led
    import pico_qsys_led_pkg::*;
#(
    parameter int          DATA_WIDTH   = 8,
    parameter logic [31:0] RESET_VALUE  = 32'h0,
    parameter int          PERIOD_WIDTH = 24,
    parameter logic [31:0] RESET_PERIOD = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [DATA_WIDTH-1:0]   RST_DATA   = RESET_VALUE[DATA_WIDTH-1:0];
    localparam logic [PERIOD_WIDTH-1:0] RST_PERIOD = RESET_PERIOD[PERIOD_WIDTH-1:0];

    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH-1:0]   r_mask;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic [31:0]             r_readdata;

    logic                    w_wr;
    logic                    w_period_wr;
    logic [DATA_WIDTH-1:0]   w_wd_data;
    logic                    w_phase;
    logic [31:0]             w_rd_mux;
    logic                    w_unused_wd;

    assign w_wr        = chipselect && !write_n;
    assign w_period_wr = w_wr && (address == ADDR_PERIOD);
    assign w_wd_data   = writedata[DATA_WIDTH-1:0];

    // Upper writedata bits are intentionally dropped.
    assign w_unused_wd = ^writedata;

    // ------------------------------------------------------------------
    // Register file. The alias registers are read-modify-write against the
    // current r_data, so back-to-back alias writes compose edge by edge.
    // STATUS and the reserved slot fall into the default and do nothing.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data   <= RST_DATA;
            r_mask   <= '0;
            r_period <= RST_PERIOD;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:   r_data   <= w_wd_data;
                ADDR_BLINK:  r_mask   <= w_wd_data;
                ADDR_PERIOD: r_period <= writedata[PERIOD_WIDTH-1:0];
                ADDR_OUTSET: r_data   <= r_data | w_wd_data;
                ADDR_OUTCLR: r_data   <= r_data & ~w_wd_data;
                ADDR_OUTTGL: r_data   <= r_data ^ w_wd_data;
                default:     ;
            endcase
        end
    end

    pico_qsys_led_blink_timer #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_blink_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (r_period),
        .restart (w_period_wr),
        .phase   (w_phase)
    );

    // ------------------------------------------------------------------
    // Read mux. Write-only aliases and the reserved slot read as zero.
    // ------------------------------------------------------------------
    // NOTE: the mux is given a full default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:   w_rd_mux[DATA_WIDTH-1:0]   = r_data;
            ADDR_BLINK:  w_rd_mux[DATA_WIDTH-1:0]   = r_mask;
            ADDR_PERIOD: w_rd_mux[PERIOD_WIDTH-1:0] = r_period;
            ADDR_STATUS: w_rd_mux[0]                = w_phase;
            default:     ;
        endcase
    end

    // readdata follows the address every cycle, selected or not.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_data ^ (r_mask & {DATA_WIDTH{w_phase}});

endmodule : pico_qsys_led

// File: tb/tb_pico_qsys_led.sv
// ----------------------------------------------------------------------------
// tb_pico_qsys_led
// Self-checking bench for pico_qsys_led (DATA_WIDTH=8, RESET_VALUE=8'hA5,
// PERIOD_WIDTH=24, RESET_PERIOD=0). Inputs change 1 ns after a rising edge
// and outputs are sampled there too, well clear of the next edge.
// ----------------------------------------------------------------------------
module tb_pico_qsys_led;
    import pico_qsys_led_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_tests;
    int n_fail;

    pico_qsys_led #(
        .DATA_WIDTH   (8),
        .RESET_VALUE  (32'hA5),
        .PERIOD_WIDTH (24),
        .RESET_PERIOD (32'h0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cs;
        logic        wn;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [7:0]  exp_out;
        string       name;
    } wvec_t;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] exp_rd;
        string       name;
    } rvec_t;

    wvec_t wv[8];
    rvec_t rv[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: present the request, let one edge take it, then idle.
    task automatic bus_cycle(input logic cs, input logic wn, input logic [2:0] addr,
                             input logic [31:0] wd);
        chipselect = cs;
        write_n    = wn;
        address    = addr;
        writedata  = wd;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] wd);
        bus_cycle(1'b1, 1'b0, addr, wd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_o;
        logic       ph;

        n_tests = 0;
        n_fail  = 0;

        wv[0] = '{1'b1, 1'b0, ADDR_DATA,   32'h0000_003C, 8'h3C, "wr_data"};
        wv[1] = '{1'b1, 1'b0, ADDR_OUTSET, 32'hFFFF_FF01, 8'h3D, "outset"};
        wv[2] = '{1'b1, 1'b0, ADDR_OUTCLR, 32'h0000_000C, 8'h31, "outclr"};
        wv[3] = '{1'b1, 1'b0, ADDR_OUTTGL, 32'h0000_00FF, 8'hCE, "outtgl"};
        wv[4] = '{1'b0, 1'b0, ADDR_DATA,   32'h0000_00FF, 8'hCE, "wr_no_cs"};
        wv[5] = '{1'b1, 1'b1, ADDR_DATA,   32'h0000_0000, 8'hCE, "wr_no_wn"};
        wv[6] = '{1'b1, 1'b0, ADDR_STATUS, 32'hFFFF_FFFF, 8'hCE, "wr_status"};
        wv[7] = '{1'b1, 1'b0, 3'd7,        32'hFFFF_FFFF, 8'hCE, "wr_rsvd"};

        rv[0] = '{ADDR_DATA,   32'h0000_00CE, "rd_data"};
        rv[1] = '{ADDR_BLINK,  32'h0000_005A, "rd_blink"};
        rv[2] = '{ADDR_PERIOD, 32'h0000_0000, "rd_period"};
        rv[3] = '{ADDR_STATUS, 32'h0000_0000, "rd_status"};
        rv[4] = '{ADDR_OUTSET, 32'h0000_0000, "rd_outset"};
        rv[5] = '{ADDR_OUTCLR, 32'h0000_0000, "rd_outclr"};
        rv[6] = '{ADDR_OUTTGL, 32'h0000_0000, "rd_outtgl"};
        rv[7] = '{3'd7,        32'h0000_0000, "rd_rsvd"};

        // ---------------- reset ----------------
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = ADDR_DATA;
        writedata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", {24'h0, out_port}, 32'hA5);
        check("rst_rd", readdata, 32'h0);
        reset_n = 1'b1;
        #1;
        check("rel_out", {24'h0, out_port}, 32'hA5);
        check("rel_rd", readdata, 32'h0);
        repeat (READ_LATENCY) @(posedge clk);
        #1;
        check("rd_reset_data", readdata, 32'hA5);

        // ---------------- write table ----------------
        for (int i = 0; i < 8; i++) begin
            bus_cycle(wv[i].cs, wv[i].wn, wv[i].addr, wv[i].wd);
            check(wv[i].name, {24'h0, out_port}, {24'h0, wv[i].exp_out});
        end

        // ---------------- read table ----------------
        wr(ADDR_BLINK, 32'h5A);
        check("blink_no_period", {24'h0, out_port}, 32'hCE);
        for (int i = 0; i < 8; i++) begin
            address = rv[i].addr;
            repeat (READ_LATENCY) @(posedge clk);
            #1;
            check(rv[i].name, readdata, rv[i].exp_rd);
        end

        // ---------------- blink, period 3 ----------------
        wr(ADDR_BLINK, 32'h0F);
        wr(ADDR_DATA, 32'h00);
        wr(ADDR_PERIOD, 32'h3);
        address = ADDR_STATUS;
        check("blk3_start", {24'h0, out_port}, 32'h00);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            ph    = ((k / 4) % 2) == 1;
            exp_o = ph ? 8'h0F : 8'h00;
            check($sformatf("blk3_out_%0d", k), {24'h0, out_port}, {24'h0, exp_o});
            check($sformatf("blk3_status_%0d", k), readdata, 32'(((k - 1) / 4) % 2));
        end

        // ---------------- period rewrite while cnt=2, phase=1 ----------------
        repeat (2) @(posedge clk);
        #1;
        wr(ADDR_PERIOD, 32'h5);
        address = ADDR_STATUS;
        check("p5_at_write", {24'h0, out_port}, 32'h0F);
        for (int j = 1; j <= 12; j++) begin
            @(posedge clk);
            #1;
            ph    = 1'b1 ^ (((j / 6) % 2) == 1);
            exp_o = ph ? 8'h0F : 8'h00;
            check($sformatf("blk5_out_%0d", j), {24'h0, out_port}, {24'h0, exp_o});
        end

        // ---------------- period 0 disables blinking ----------------
        wr(ADDR_PERIOD, 32'h0);
        address = ADDR_STATUS;
        for (int j = 1; j <= 3; j++) begin
            @(posedge clk);
            #1;
            check($sformatf("p0_out_%0d", j), {24'h0, out_port}, 32'h00);
            if (j >= 2) check($sformatf("p0_status_%0d", j), readdata, 32'h0);
        end

        // ---------------- async reset mid-blink ----------------
        wr(ADDR_DATA, 32'h55);
        wr(ADDR_PERIOD, 32'h2);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_out", {24'h0, out_port}, 32'h5A);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_out", {24'h0, out_port}, 32'hA5);
        check("async_rst_rd", readdata, 32'h0);
        @(posedge clk);
        #1;
        check("in_rst_out", {24'h0, out_port}, 32'hA5);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", {24'h0, out_port}, 32'hA5);
        wr(ADDR_BLINK, 32'h0F);
        wr(ADDR_PERIOD, 32'h2);
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk);
            #1;
            ph    = ((j / 3) % 2) == 1;
            exp_o = ph ? 8'hAA : 8'hA5;
            check($sformatf("post_rst_blk_%0d", j), {24'h0, out_port}, {24'h0, exp_o});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pico_qsys_led
